// File: rtl/servo_pkg.sv
// Shared constants and the default pose table for the servo pose controller.
// Default table: 4 poses x N_CH channels, each CNT_W bits, entry [p][ch] at (p*N_CH+ch)*CNT_W.
package servo_pkg;

  localparam int unsigned POSE_W        = 2;
  localparam int unsigned NUM_POSES     = 4;
  localparam int unsigned MAX_CH        = 8;
  localparam int unsigned MAX_W         = 32;
  localparam int unsigned EXTRA_CH_DUTY = 97500;
  localparam int unsigned TBL_MAX_W     = NUM_POSES * MAX_CH * MAX_W;
  localparam int unsigned TBL_IDX_W     = $clog2(TBL_MAX_W);

  // Base duties for ch0..ch2, packed as [p][ch] at (p*3+ch)*32.
  localparam logic [NUM_POSES*3*32-1:0] DEFAULT_FLAT = {
    32'd97500,  32'd97500,  32'd75000,
    32'd145000, 32'd50000,  32'd100000,
    32'd50000,  32'd50000,  32'd50000,
    32'd145000, 32'd145000, 32'd100000
  };

  function automatic logic [MAX_W-1:0] default_duty(input int unsigned p, input int unsigned ch);
    logic [MAX_W-1:0] duty;
    if (ch >= 3) begin
      duty = EXTRA_CH_DUTY;
    end else begin
      duty = MAX_W'(DEFAULT_FLAT >> ((p * 3 + ch) * 32));
    end
    return duty;
  endfunction

  function automatic logic [TBL_MAX_W-1:0] default_table(input int unsigned n_ch,
                                                          input int unsigned cnt_w);
    logic [TBL_MAX_W-1:0] tbl;
    logic [MAX_W-1:0]     duty;
    logic [TBL_IDX_W-1:0] idx;
    tbl = '0;
    for (int unsigned p = 0; p < NUM_POSES; p++) begin
      for (int unsigned ch = 0; ch < n_ch; ch++) begin
        duty = default_duty(p, ch);
        for (int unsigned b = 0; b < cnt_w; b++) begin
          idx      = TBL_IDX_W'((p * n_ch + ch) * cnt_w + b);
          tbl[idx] = duty[0];
          duty     = duty >> 1;
        end
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/servo_ramp_ch.sv
// One servo channel: slews its duty toward the target once per frame and drives the
// registered PWM compare against the shared frame counter.
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int unsigned      CNT_W    = 21,
  parameter int unsigned      STEP     = 2500,
  parameter logic [CNT_W-1:0] RST_DUTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  input  logic [CNT_W-1:0] fcnt,
  input  logic [CNT_W-1:0] tgt,
  output logic             pwm,
  output logic             at_tgt
);

  localparam logic [CNT_W:0] StepC = (CNT_W + 1)'(STEP);

  logic [CNT_W-1:0] cur_q, cur_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W:0]   diff;

  always_comb begin
    cur_d = cur_q;
    diff  = '0;
    if (frame_end) begin
      if (tgt >= cur_q) begin
        diff  = {1'b0, tgt} - {1'b0, cur_q};
        cur_d = (diff <= StepC) ? tgt : CNT_W'({1'b0, cur_q} + StepC);
      end else begin
        diff  = {1'b0, cur_q} - {1'b0, tgt};
        cur_d = (diff <= StepC) ? tgt : CNT_W'({1'b0, cur_q} - StepC);
      end
    end
  end

  // cur = PERIOD keeps the compare true on every count, so the pulse never gaps at the wrap.
  always_comb begin
    pwm_d  = (fcnt < cur_q);
    at_tgt = (cur_q == tgt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= RST_DUTY;
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/servo_pose_ctrl.sv
// Multi-channel servo pose controller: synchronised, debounced pose select feeding
// per-channel ramped PWM generators that share one frame counter.
module servo_pose_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned CNT_W      = 21,
  parameter int unsigned PERIOD     = 2000000,
  parameter int unsigned STEP       = 2500,
  parameter int unsigned STABLE_CYC = 1000000,
  parameter logic [NUM_POSES*N_CH*CNT_W-1:0] POSE_TABLE =
      (NUM_POSES * N_CH * CNT_W)'(default_table(N_CH, CNT_W))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              manual_on,
  input  logic [POSE_W-1:0] sw,
  input  logic [POSE_W-1:0] rpi,
  output logic [N_CH-1:0]   out,
  output logic [POSE_W-1:0] pose,
  output logic              settled
);

  localparam int unsigned     StabW    = $clog2(STABLE_CYC);
  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] PeriodC = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PeriodM1 = CNT_W'(PERIOD - 1);

  logic              manual_meta_q, manual_sync_q;
  logic [POSE_W-1:0] sw_meta_q, sw_sync_q, rpi_meta_q, rpi_sync_q;
  logic [POSE_W-1:0] code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      manual_meta_q <= 1'b0;
      manual_sync_q <= 1'b0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      rpi_meta_q    <= '0;
      rpi_sync_q    <= '0;
    end else begin
      manual_meta_q <= manual_on;
      manual_sync_q <= manual_meta_q;
      sw_meta_q     <= sw;
      sw_sync_q     <= sw_meta_q;
      rpi_meta_q    <= rpi;
      rpi_sync_q    <= rpi_meta_q;
    end
  end

  assign code = manual_sync_q ? sw_sync_q : rpi_sync_q;

  logic [POSE_W-1:0] cand_q, cand_d, pose_q, pose_d;
  logic [StabW-1:0]  stab_q, stab_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              frame_end;
  logic [N_CH-1:0]   at_tgt;
  logic              settled_q, settled_d;

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    pose_d = pose_q;
    if (code != cand_q) begin
      cand_d = code;
      stab_d = '0;
    end else if (stab_q != StabMax) begin
      stab_d = stab_q + 1'b1;
    end
    // A code that flips on the accepting cycle was still stable for the full window.
    if (stab_q == StabMax) begin
      pose_d = cand_q;
    end
  end

  always_comb begin
    frame_end = (fcnt_q == PeriodM1);
    fcnt_d    = frame_end ? '0 : fcnt_q + 1'b1;
    settled_d = &at_tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q    <= 2'b11;
      pose_q    <= 2'b11;
      stab_q    <= '0;
      fcnt_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      cand_q    <= cand_d;
      pose_q    <= pose_d;
      stab_q    <= stab_d;
      fcnt_q    <= fcnt_d;
      settled_q <= settled_d;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam int unsigned      RstOff  = ((NUM_POSES - 1) * N_CH + ch) * CNT_W;
    localparam logic [CNT_W-1:0] RstDuty = CNT_W'(POSE_TABLE >> RstOff);

    logic [CNT_W-1:0] raw;
    logic [CNT_W-1:0] tgt;

    always_comb begin
      raw = CNT_W'(POSE_TABLE >> ((32'(pose_q) * N_CH + ch) * CNT_W));
      tgt = (raw > PeriodC) ? PeriodC : raw;
    end

    servo_ramp_ch #(
      .CNT_W    (CNT_W),
      .STEP     (STEP),
      .RST_DUTY (RstDuty)
    ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .frame_end (frame_end),
      .fcnt      (fcnt_q),
      .tgt       (tgt),
      .pwm       (out[ch]),
      .at_tgt    (at_tgt[ch])
    );
  end

  assign pose    = pose_q;
  assign settled = settled_q;

endmodule

// File: doc/servo_pose_ctrl.md
# servo_pose_ctrl

Parametrised multi-channel servo PWM controller that succeeds the fixed 3-channel pose decoder at the top of the hand design. It selects a pose code from the Raspberry Pi or the manual switches, synchronises and debounces it, looks up per-channel target pulse widths, and slews each channel toward its target once per PWM frame. All channels share one frame counter, so their pulses are phase-aligned, and duty changes only at frame boundaries (glitch-free).

## Interface
Parameters:
- N_CH, 3: servo channel count (1..8).
- CNT_W, 21: frame-counter and duty width.
- PERIOD, 2000000: frame length in clk cycles (20 ms at 100 MHz); must be < 2^CNT_W.
- STEP, 2500: maximum duty change per frame per channel (>0).
- STABLE_CYC, 1000000: cycles a new pose code must be unchanged before it is accepted (≥2).
- POSE_TABLE, package default: flat vector of 4×N_CH×CNT_W bits. Entry [p][ch] sits at bit offset (p×N_CH+ch)×CNT_W.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- manual_on, in, 1: 1 selects sw, 0 selects rpi; asynchronous input.
- sw, in, 2: manual pose code; asynchronous.
- rpi, in, 2: Pi pose code; asynchronous.
- out, out, N_CH: PWM outputs, one per servo.
- pose, out, 2: currently accepted pose code.
- settled, out, 1: 1 when every channel duty equals its target.

## Operation
- Input path: manual_on, sw and rpi each pass through a 2-FF synchroniser. The mux then takes the synchronised values: code = manual_on_s ? sw_s : rpi_s.
- Filter: the candidate register holds the last code. When code ≠ candidate, load candidate and clear the counter. Otherwise the counter increments, saturating. When the counter reaches STABLE_CYC−1, load pose ← candidate. A source switch is simply another code change.
- Target: tgt[ch] = POSE_TABLE[pose][ch], clamped to PERIOD.
- Frame counter fcnt runs 0..PERIOD−1 and wraps to 0.
- Ramp: update cur[ch] only on the cycle fcnt == PERIOD−1.
  - If |tgt−cur| ≤ STEP, then cur ← tgt.
  - Else cur ← cur ± STEP toward tgt.
  - Use unsigned arithmetic with a CNT_W+1-bit difference; no overflow is permitted.
- Output: out[ch] = (fcnt < cur[ch]), registered.
  - cur = 0 gives constant low.
  - cur = PERIOD gives constant high.
- settled = AND over ch of (cur[ch] == tgt[ch]), registered.
- Reset values:
  - fcnt = 0.
  - Synchronisers = 0.
  - candidate = pose = 2'b11; filter counter = 0.
  - cur[ch] = POSE_TABLE[3][ch].
  - out = 0; settled = 1.

## Timing
- Input to accepted pose: 2 sync cycles + STABLE_CYC cycles + 1 register cycle.
- A pose change takes effect on the next frame-end update, so the first changed pulse starts at the next fcnt = 0.
- Worst-case slew time: ceil(|Δ|/STEP) frames.
- out is registered: it rises on the cycle after fcnt = 0 and falls on the cycle after fcnt = cur.
- A pose change mid-ramp retargets immediately. The next update steps from the current cur, and cur never jumps.
- A pose change on the same cycle as the frame-end update: the update uses the old tgt; the new tgt applies from the next frame.
- rst asserted mid-frame: all state returns to its reset values immediately. After release, the first frame starts at fcnt = 0.

## Structure
- Package servo_pkg holds:
  - the default POSE_TABLE for N_CH = 3: pose0 {100000,145000,145000}, pose1 {50000,50000,50000}, pose2 {100000,50000,145000}, pose3 {75000,97500,97500}, listed as ch0..ch2;
  - the pose-code width constant (2);
  - the rule that channels ≥3 default to 97500.
- One sub-module, servo_ramp_ch, is instantiated N_CH times. It contains the cur register, the ramp arithmetic and the PWM compare. The top holds the synchronisers, filter, table lookup and shared fcnt.

## Test plan
Bench parameters: PERIOD = 100, STEP = 10, STABLE_CYC = 4, N_CH = 3, table pose0 {50,80,20}, pose1 {0,100,40}, pose2 {30,30,30}, pose3 {40,60,60}.
- Reset: after rst release, out is high for exactly 40/60/60 cycles of each 100-cycle frame; pose = 3; settled = 1.
- Ramp: hold rpi = 0 with manual_on = 0. Expect pose = 0 after 7 cycles. ch0 width goes 50 (one frame), ch1 goes 70 then 80, ch2 goes 50, 40, 30, 20. settled rises when ch2 reaches 20.
- Glitch filter: rpi pulses to 1 for 3 cycles, then returns to 3. Expect pose unchanged, widths unchanged, settled stays 1.
- Clamp/extremes: pose1 is reached by ramping. ch0 ends at constant low; ch1 ends at constant high, with no gap across the frame wrap.
- Source select: rpi = 0, sw = 2, manual_on toggles 0→1 mid-ramp. Expect pose = 2 after 7 cycles; ramp retargets from current widths without a jump.
- Async reset mid-frame at fcnt = 37: out goes 0 immediately. After release, fcnt restarts at 0 and widths return to 40/60/60.
